// File: rtl/seg_pkg.sv
// Shared seven-segment constants: glyph table and the active-low segment convention.
package seg_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;

   // Glyphs are stored active-low {a,b,c,d,e,f,g}: a 0 bit lights the segment.
   localparam logic SEG_LIT = 1'b0;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   localparam logic [SEG_W-1:0] SEG_HEX [0:15] = '{
      7'b0000001, // 0
      7'b1001111, // 1
      7'b0010010, // 2
      7'b0000110, // 3
      7'b1001100, // 4
      7'b0100100, // 5
      7'b0100000, // 6
      7'b0001111, // 7
      7'b0000000, // 8
      7'b0000100, // 9
      7'b0001000, // A
      7'b1100000, // b
      7'b0110001, // C
      7'b1000010, // d
      7'b0110000, // E
      7'b0111000  // F
   };

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seven_seg_glyph
   import seg_pkg::*;
(
   input  logic [NIB_W-1:0] nibble_i,
   output logic [SEG_W-1:0] glyph_c
);

   // Table lookup into the shared glyph ROM.
   always_comb begin
      glyph_c = SEG_HEX[nibble_i];
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous double buffering
// and optional leading-zero blanking.
module seven_seg_scan
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic                    enable,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int unsigned VAL_W  = NIB_W * NUM_DIGITS;
   localparam int unsigned PCNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

   // Pin polarity masks: internal values are active-low, XOR flips them for active-high boards.
   localparam logic [SEG_W-1:0]      SEG_INV = ACTIVE_LOW ? '0 : '1;
   localparam logic [NUM_DIGITS-1:0] AN_INV  = ACTIVE_LOW ? '0 : '1;
   localparam logic                  DP_INV  = ~ACTIVE_LOW;

   localparam logic [SEG_W-1:0]      SEG_OFF = SEG_BLANK ^ SEG_INV;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{1'b1}} ^ AN_INV;
   localparam logic                  DP_OFF  = 1'b1 ^ DP_INV;

   logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [VAL_W-1:0]      disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  fs_q, fs_d;

   logic                  tick;
   logic                  wrap;
   logic [NIB_W-1:0]      nib;
   logic                  dp_bit;
   logic                  upper_zero;
   logic                  blank;
   logic [SEG_W-1:0]      glyph;

   // Prescaler and scan index; wrap marks the last clock of a frame.
   always_comb begin
      tick   = (pcnt_q == PCNT_MAX);
      wrap   = tick && (idx_q == IDX_MAX);
      pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
      idx_d  = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Double buffer: loads park in pending, display is only replaced on the frame wrap.
   always_comb begin
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_vld_d = pend_vld_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      if (wrap) begin
         pend_vld_d = 1'b0;
         if (load) begin
            disp_val_d = value;
            disp_dp_d  = dp_in;
         end else if (pend_vld_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
         end
      end else if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp_in;
         pend_vld_d = 1'b1;
      end
   end

   // Digit mux and leading-zero detect, evaluated on next-state so pins track idx with no lag.
   always_comb begin
      nib        = '0;
      dp_bit     = 1'b0;
      upper_zero = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            nib    = disp_val_d[NIB_W*k +: NIB_W];
            dp_bit = disp_dp_d[k];
         end
         if ((IDX_W'(k) >= idx_d) && (disp_val_d[NIB_W*k +: NIB_W] != '0)) begin
            upper_zero = 1'b0;
         end
      end
      blank = blank_lz && (idx_d != '0) && upper_zero;
   end

   seven_seg_glyph u_glyph (
      .nibble_i (nib),
      .glyph_c  (glyph)
   );

   // Pin values for the next cycle; enable low forces everything dark.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
      fs_d  = wrap;
      if (enable) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_d) ^ AN_INV;
         seg_d = (blank ? SEG_BLANK : glyph) ^ SEG_INV;
         dp_d  = ~dp_bit ^ DP_INV;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q     <= '0;
         idx_q      <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_vld_q <= 1'b0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         seg_q      <= SEG_OFF;
         dp_q       <= DP_OFF;
         an_q       <= AN_OFF;
         fs_q       <= 1'b0;
      end else begin
         pcnt_q     <= pcnt_d;
         idx_q      <= idx_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_vld_q <= pend_vld_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         fs_q       <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign an          = an_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
module tb_seven_seg_scan;

   localparam logic [6:0] G0 = 7'b0000001;
   localparam logic [6:0] G1 = 7'b1001111;
   localparam logic [6:0] G2 = 7'b0010010;
   localparam logic [6:0] G3 = 7'b0000110;
   localparam logic [6:0] G5 = 7'b0100100;
   localparam logic [6:0] G7 = 7'b0001111;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GF = 7'b0111000;
   localparam logic [6:0] GB = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic [3:0]  dp_in = '0;
   logic        blank_lz = 1'b0;
   logic        enable = 1'b1;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   seven_seg_scan #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .load        (load),
      .dp_in       (dp_in),
      .blank_lz    (blank_lz),
      .enable      (enable),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Steps to the negedge on which frame_start is seen, bounded.
   task automatic wait_frame(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) got = 1'b1;
      end
      chk({tag, " frame_start seen"}, 32'(got), 32'd1);
   endtask

   // Checks one 16-clock frame starting at a frame_start negedge; can inject two loads
   // and an enable-low window (drive cycles en_from..en_to).
   task automatic check_frame(input string fn, input logic [27:0] es, input logic [3:0] edp,
                              input int la, input logic [15:0] va, input logic [3:0] da,
                              input int lb, input logic [15:0] vb, input logic [3:0] db,
                              input int en_from, input int en_to);
      for (int t = 0; t < 16; t++) begin
         int         d;
         logic       dark;
         logic [3:0] ean;
         logic [6:0] eseg;
         logic       edpin;
         d     = t / 4;
         dark  = (t - 1 >= en_from) && (t - 1 <= en_to);
         ean   = dark ? 4'b1111 : ~(4'(4'b0001 << d));
         eseg  = dark ? 7'b1111111 : es[7*d +: 7];
         edpin = dark ? 1'b1 : ~edp[d];
         chk($sformatf("%s t%0d frame_start", fn, t), 32'(frame_start), 32'(t == 0));
         chk($sformatf("%s t%0d an", fn, t), 32'(an), 32'(ean));
         chk($sformatf("%s t%0d seg", fn, t), 32'(seg), 32'(eseg));
         chk($sformatf("%s t%0d dp", fn, t), 32'(dp), 32'(edpin));
         load = 1'b0;
         if (t == la) begin
            load = 1'b1; value = va; dp_in = da;
         end
         if (t == lb) begin
            load = 1'b1; value = vb; dp_in = db;
         end
         enable = !((t >= en_from) && (t <= en_to));
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset an", 32'(an), 32'b1111);
      chk("reset seg", 32'(seg), 32'(GB));
      chk("reset dp", 32'(dp), 32'd1);
      chk("reset frame_start", 32'(frame_start), 32'd0);
      rst = 1'b0;

      wait_frame("startup");
      // Frame A: zeros; mid-frame load of 1A3F must not show yet.
      check_frame("A", {G0, G0, G0, G0}, 4'b0000, 5, 16'h1A3F, 4'b0100, -1, '0, '0, -1, -2);
      blank_lz = 1'b1;
      // Frame B: 1A3F, dp on digit 2; queue 0050.
      check_frame("B", {G1, GA, G3, GF}, 4'b0100, 2, 16'h0050, 4'b0000, -1, '0, '0, -1, -2);
      // Frame C: 0050 with leading-zero blanking; queue 0000.
      check_frame("C", {GB, GB, G5, G0}, 4'b0000, 7, 16'h0000, 4'b0000, -1, '0, '0, -1, -2);
      // Frame D: all zero, only digit 0 lit; two loads, last wins.
      check_frame("D", {GB, GB, GB, G0}, 4'b0000, 2, 16'h1111, 4'b0000, 9, 16'h2222, 4'b0000, -1, -2);
      // Frame E: 2222; pending 0333 overridden by a load on the wrap cycle.
      check_frame("E", {G2, G2, G2, G2}, 4'b0000, 3, 16'h0333, 4'b1111, 15, 16'h0087, 4'b0001, -1, -2);
      // Frame F: 0087 blanked, dp on digit 0.
      check_frame("F", {GB, GB, G8, G7}, 4'b0001, -1, '0, '0, -1, '0, '0, -1, -2);
      // Frame G: enable low for 10 clocks.
      check_frame("G", {GB, GB, G8, G7}, 4'b0001, -1, '0, '0, -1, '0, '0, 5, 14);
      // Frame H: scan still aligned after re-enable.
      check_frame("H", {GB, GB, G8, G7}, 4'b0001, -1, '0, '0, -1, '0, '0, -1, -2);

      // Mid-digit async reset discards a pending load.
      blank_lz = 1'b0;
      load = 1'b1; value = 16'h0999; dp_in = 4'b1111;
      @(negedge clk);
      load = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async reset an", 32'(an), 32'b1111);
      chk("async reset seg", 32'(seg), 32'(GB));
      chk("async reset dp", 32'(dp), 32'd1);
      chk("async reset frame_start", 32'(frame_start), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post reset an", 32'(an), 32'b1110);
      chk("post reset seg", 32'(seg), 32'(G0));
      chk("post reset dp", 32'(dp), 32'd1);
      wait_frame("post reset");
      check_frame("R", {G0, G0, G0, G0}, 4'b0000, -1, '0, '0, -1, '0, '0, -1, -2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
